display_scan_driver: RTL
========================

DISPLAY_SCAN_DRIVER -- requirements
Module: display_scan_driver

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, meaning clock cycles each digit is held before the scan advances (minimum 2).
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000, meaning cycles ModeBtn must stay stable before a press or release is accepted (minimum 2).
REQ-003 Port Clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 Port Rst  input  1  asynchronous, active-low reset.
REQ-005 Port PC_in  input  32  program counter from the processor core.
REQ-006 Port WriteData_in  input  32  write-back data from the processor core.
REQ-007 Port HiReg_in  input  32  HI register value.
REQ-008 Port LoReg_in  input  32  LO register value.
REQ-009 Port ModeBtn  input  1  raw, asynchronous push-button that cycles the displayed word.
REQ-010 Port Freeze  input  1  synchronous level; while high, the snapshot holds.
REQ-011 Port Seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-012 Port An  output  8  digit anodes, active-low, one-cold while scanning.
REQ-013 Port Dp  output  1  decimal point, active-low.
REQ-014 Port Mode  output  2  selected word: 0=PC, 1=WriteData, 2=Hi, 3=Lo.

Function
REQ-015 Snapshot: four 32-bit registers load the corresponding inputs every cycle when Freeze=0 and hold when Freeze=1.
REQ-016 Refresh counter: counts 0..REFRESH_DIV-1 and wraps; a tick is asserted on the terminal count.
REQ-017 Digit index: 3-bit, increments on each tick, wraps 7->0.
REQ-018 The displayed nibble is bits [4*idx+3:4*idx] of the snapshot selected by Mode; digit 0 is the rightmost digit.
REQ-019 Seg, An and Dp are registered and reflect the current idx, Mode and snapshot with one cycle of latency.
REQ-020 An equals ~(1<<idx).
REQ-021 Seg is the hex glyph for values 0-F (b and d lower-case).
REQ-022 Dp=0 only when idx=0 and Freeze=1; otherwise Dp=1.
REQ-023 Mode increments by 1 on each accepted press and wraps 3->0; a change of Mode does not reset idx or the refresh counter.
REQ-024 ModeBtn passes through a 2-flop synchronizer before any use.
REQ-025 Debounce FSM states:
  - IDLE: synced=1 -> PRESS_WAIT.
  - PRESS_WAIT: synced=0 -> IDLE; counter reaches DEBOUNCE_CYCLES-1 -> PRESSED, and Mode increments on this transition.
  - PRESSED: synced=0 -> RELEASE_WAIT.
  - RELEASE_WAIT: synced=1 -> PRESSED; counter reaches DEBOUNCE_CYCLES-1 -> IDLE.
  - The debounce counter clears on every state change.
REQ-026 Holding the button produces exactly one Mode increment; a glitch shorter than DEBOUNCE_CYCLES produces none.
REQ-027 When Freeze and a press are accepted in the same cycle, both take effect, and the new Mode shows the frozen snapshot.

Reset
REQ-028 While Rst=0:
  - snapshots = 0, Mode = 0, idx = 0, all counters = 0;
  - FSM = IDLE, synchronizer flops = 0;
  - Seg = 7'h7F, An = 8'hFF, Dp = 1.
REQ-029 On the first rising edge after Rst deasserts, An = 8'hFE and Seg shows nibble 0 of the zero snapshot (glyph "0").
REQ-030 Reset asserted mid-press or mid-scan aborts immediately to the REQ-028 values; no Mode increment is committed.

Configuration
REQ-031 Macro DISP_DEBOUNCE_EN selects the press logic:
  - Defined: the REQ-025 FSM and counter are compiled in.
  - Undefined: the FSM and counter are omitted, DEBOUNCE_CYCLES is ignored, and Mode increments on each synchronized 0->1 edge of ModeBtn.

Structure
REQ-032 Shared package disp_pkg holds:
  - mode constants MODE_PC, MODE_WD, MODE_HI, MODE_LO;
  - debounce state encoding;
  - SEG_BLANK = 7'h7F and AN_OFF = 8'hFF.
REQ-033 One sub-module, hex_to_7seg, is a combinational decoder from a 4-bit nibble to 7-bit active-low segments.

Verification (REFRESH_DIV=4, DEBOUNCE_CYCLES=8)
REQ-034 Reset, then PC_in=32'h0040_0010 with Freeze=0 -> An steps FE,FD,FB,...,7F, each held 4 cycles, then wraps; Seg glyphs from digit 0 upward are 0,1,0,0,0,4,0,0.
REQ-035 ModeBtn held high for 20 cycles -> Mode goes 0->1 exactly once, 9-10 cycles after the press; four further presses -> Mode reads 2,3,0,1.
REQ-036 ModeBtn pulsed high for 3 cycles (DISP_DEBOUNCE_EN defined) -> Mode unchanged; same pulse with the macro undefined -> Mode increments once.
REQ-037 Freeze=1 while WriteData_in changes from 32'hDEAD_BEEF to 32'h0 with Mode=1 -> the display keeps showing DEADBEEF, and Dp=0 only while An=FE.
REQ-038 Rst asserted asynchronously mid-scan and mid-debounce -> Seg=7F, An=FF, Mode=0 immediately, with no increment after release.

Source files
------------

// File: rtl/display_scan_driver_pkg.sv
// disp_pkg: constants shared by the display scan driver and its decoder.
//   - MODE_* : which snapshot word is shown (PC, WriteData, HI, LO)
//   - deb_state_e : debounce FSM state encoding
//   - SEG_BLANK / AN_OFF : all segments and all anodes off (active-low)
package disp_pkg;

  localparam logic [1:0] MODE_PC = 2'd0;
  localparam logic [1:0] MODE_WD = 2'd1;
  localparam logic [1:0] MODE_HI = 2'd2;
  localparam logic [1:0] MODE_LO = 2'd3;

  typedef enum logic [1:0] {
    DEB_IDLE         = 2'd0,
    DEB_PRESS_WAIT   = 2'd1,
    DEB_PRESSED      = 2'd2,
    DEB_RELEASE_WAIT = 2'd3
  } deb_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF    = 8'hFF;

endpackage

// File: rtl/display_scan_driver_hex_to_7seg.sv
// hex_to_7seg: combinational hex digit decoder.
//   nibble : 4-bit value 0-F
//   seg    : {g,f,e,d,c,b,a}, active-low; b and d drawn lower-case
module hex_to_7seg
  import disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    unique case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_scan_driver.sv
// display_scan_driver: scans one of four captured 32-bit processor words onto an
// 8-digit multiplexed seven-segment display.
//   Clk           system clock (rising edge)
//   Rst           asynchronous active-low reset
//   PC_in, WriteData_in, HiReg_in, LoReg_in : words that can be displayed
//   ModeBtn       raw push-button, cycles Mode
//   Freeze        while high the captured words hold
//   Seg, An, Dp   registered active-low segment / anode / decimal-point drives
//   Mode          currently selected word (0=PC 1=WD 2=HI 3=LO)
// Build option: DISP_DEBOUNCE_EN compiles in the debounce FSM; without it Mode
// steps on every synchronized rising edge of ModeBtn.
module display_scan_driver
  import disp_pkg::*;
#(
  parameter int REFRESH_DIV     = 100000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] PC_in,
  input  logic [31:0] WriteData_in,
  input  logic [31:0] HiReg_in,
  input  logic [31:0] LoReg_in,
  input  logic        ModeBtn,
  input  logic        Freeze,
  output logic [6:0]  Seg,
  output logic [7:0]  An,
  output logic        Dp,
  output logic [1:0]  Mode
);

  localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  // Snapshot registers, indexed by mode value.
  logic [31:0] word_in  [4];
  logic [31:0] snap_reg [4];

  assign word_in[0] = PC_in;
  assign word_in[1] = WriteData_in;
  assign word_in[2] = HiReg_in;
  assign word_in[3] = LoReg_in;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_snap
      always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst)        snap_reg[gi] <= '0;
        else if (!Freeze) snap_reg[gi] <= word_in[gi];
      end
    end
  endgenerate

  // Refresh counter and digit index.
  logic [RW-1:0] refresh_cnt_reg;
  logic [2:0]    idx_reg;
  logic          tick;

  assign tick = (refresh_cnt_reg == RW'(REFRESH_DIV - 1));

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      refresh_cnt_reg <= '0;
      idx_reg         <= '0;
    end else if (tick) begin
      refresh_cnt_reg <= '0;
      idx_reg         <= idx_reg + 3'd1;
    end else begin
      refresh_cnt_reg <= refresh_cnt_reg + RW'(1);
    end
  end

  // Button synchronizer; only btn_sync_reg[1] is used downstream.
  logic [1:0] btn_sync_reg;
  logic       btn_synced;
  logic [1:0] mode_reg;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) btn_sync_reg <= '0;
    else      btn_sync_reg <= {btn_sync_reg[0], ModeBtn};
  end

  assign btn_synced = btn_sync_reg[1];

`ifdef DISP_DEBOUNCE_EN
  localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  deb_state_e    deb_state_reg;
  logic [DW-1:0] deb_cnt_reg;
  logic          deb_done;

  assign deb_done = (deb_cnt_reg == DW'(DEBOUNCE_CYCLES - 1));

  // Counter runs only in the two wait states and clears on every transition.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      deb_state_reg <= DEB_IDLE;
      deb_cnt_reg   <= '0;
      mode_reg      <= MODE_PC;
    end else begin
      unique case (deb_state_reg)
        DEB_IDLE: begin
          deb_cnt_reg <= '0;
          if (btn_synced) deb_state_reg <= DEB_PRESS_WAIT;
        end
        DEB_PRESS_WAIT: begin
          if (!btn_synced) begin
            deb_state_reg <= DEB_IDLE;
            deb_cnt_reg   <= '0;
          end else if (deb_done) begin
            deb_state_reg <= DEB_PRESSED;
            deb_cnt_reg   <= '0;
            mode_reg      <= mode_reg + 2'd1;
          end else begin
            deb_cnt_reg <= deb_cnt_reg + DW'(1);
          end
        end
        DEB_PRESSED: begin
          deb_cnt_reg <= '0;
          if (!btn_synced) deb_state_reg <= DEB_RELEASE_WAIT;
        end
        DEB_RELEASE_WAIT: begin
          if (btn_synced) begin
            deb_state_reg <= DEB_PRESSED;
            deb_cnt_reg   <= '0;
          end else if (deb_done) begin
            deb_state_reg <= DEB_IDLE;
            deb_cnt_reg   <= '0;
          end else begin
            deb_cnt_reg <= deb_cnt_reg + DW'(1);
          end
        end
        default: begin
          deb_state_reg <= DEB_IDLE;
          deb_cnt_reg   <= '0;
        end
      endcase
    end
  end
`else
  logic btn_prev_reg;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      btn_prev_reg <= 1'b0;
      mode_reg     <= MODE_PC;
    end else begin
      btn_prev_reg <= btn_synced;
      if (btn_synced && !btn_prev_reg) mode_reg <= mode_reg + 2'd1;
    end
  end
`endif

  assign Mode = mode_reg;

  // Digit selection and decode.
  logic [31:0] sel_word;
  logic [3:0]  nibble;
  logic [6:0]  glyph;

  always_comb begin
    sel_word = snap_reg[0];
    unique case (mode_reg)
      MODE_PC: sel_word = snap_reg[0];
      MODE_WD: sel_word = snap_reg[1];
      MODE_HI: sel_word = snap_reg[2];
      MODE_LO: sel_word = snap_reg[3];
      default: sel_word = snap_reg[0];
    endcase
  end

  assign nibble = sel_word[{idx_reg, 2'b00} +: 4];

  hex_to_7seg u_dec (
    .nibble (nibble),
    .seg    (glyph)
  );

  // Registered display drives.
  logic [6:0] seg_reg;
  logic [7:0] an_reg;
  logic       dp_reg;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      seg_reg <= SEG_BLANK;
      an_reg  <= AN_OFF;
      dp_reg  <= 1'b1;
    end else begin
      seg_reg <= glyph;
      an_reg  <= ~(8'b1 << idx_reg);
      dp_reg  <= !((idx_reg == 3'd0) && Freeze);
    end
  end

  assign Seg = seg_reg;
  assign An  = an_reg;
  assign Dp  = dp_reg;

endmodule
